frame_sync_detector: RTL and testbench



---
 rtl/frame_sync_detector.sv | 168 ++++++++++++++++
 tb/tb_frame_sync_detector.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sync_detector.sv
// Byte-parallel frame synchroniser: hunts for a two-byte sync word, verifies alignment
// over LOCK_CNT frames, then emits payload bytes with SOF/EOF and flywheels through sync errors.
module frame_sync_detector #(
    parameter int                   NBITS       = 8,
    parameter logic [2*NBITS-1:0]   SYNC_WORD   = 16'hF628,
    parameter int                   PAYLOAD_LEN = 30,
    parameter int                   LOCK_CNT    = 3,
    parameter int                   LOSS_CNT    = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [NBITS-1:0] DATA_IN,
    output logic [NBITS-1:0] DATA_OUT,
    output logic             VALID_OUT,
    output logic             SOF_OUT,
    output logic             EOF_OUT,
    output logic             LOCKED,
    output logic [15:0]      SYNC_ERR_CNT
);

    localparam int FRAME  = PAYLOAD_LEN + 2;
    localparam int POS_W  = $clog2(FRAME);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(LOSS_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME - 1);
    localparam logic [POS_W-1:0]  POS_EOF   = POS_W'(PAYLOAD_LEN - 1);
    localparam logic [POS_W-1:0]  POS_SYNC  = POS_W'(PAYLOAD_LEN);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic [NBITS-1:0]    prev_q, prev_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic [BAD_W-1:0]    bad_q, bad_d;
    logic [15:0]         err_q, err_d;
    logic [NBITS-1:0]    data_q, data_d;
    logic                valid_q, valid_d;
    logic                sof_q, sof_d;
    logic                eof_q, eof_d;

    logic                sync_hit;
    logic                at_check;
    logic [POS_W-1:0]    pos_inc;

    assign sync_hit = ({prev_q, DATA_IN} == SYNC_WORD);
    assign at_check = (pos_q == POS_LAST);
    assign pos_inc  = at_check ? '0 : pos_q + POS_W'(1);

    // NOTE: every variable gets its default first so no path through the block infers a latch.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        prev_d  = prev_q;
        good_d  = good_q;
        bad_d   = bad_q;
        err_d   = err_q;
        data_d  = data_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;

        if (EN) begin
            prev_d = DATA_IN;
            unique case (state_q)
                ST_HUNT: begin
                    if (sync_hit) begin
                        pos_d   = '0;
                        good_d  = GOOD_W'(1);
                        bad_d   = '0;
                        state_d = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
                    end
                end

                ST_VERIFY: begin
                    pos_d = pos_inc;
                    if (at_check) begin
                        if (sync_hit) begin
                            good_d = good_q + GOOD_W'(1);
                            if (good_q == GOOD_LAST) begin
                                state_d = ST_LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            // The failing byte is consumed here, not re-tested as a hunt candidate.
                            state_d = ST_HUNT;
                            good_d  = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    pos_d = pos_inc;
                    if (pos_q < POS_SYNC) begin
                        data_d  = DATA_IN;
                        valid_d = 1'b1;
                        sof_d   = (pos_q == '0);
                        eof_d   = (pos_q == POS_EOF);
                    end
                    if (at_check) begin
                        if (sync_hit) begin
                            bad_d = '0;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                            if (err_q != 16'hFFFF) begin
                                err_d = err_q + 16'd1;
                            end
                            if (bad_q == BAD_LAST) begin
                                state_d = ST_HUNT;
                                pos_d   = '0;
                                good_d  = '0;
                                bad_d   = '0;
                            end
                        end
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                    pos_d   = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_HUNT;
            pos_q   <= '0;
            prev_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            prev_q  <= prev_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign DATA_OUT     = data_q;
    assign VALID_OUT    = valid_q;
    assign SOF_OUT      = sof_q;
    assign EOF_OUT      = eof_q;
    assign LOCKED       = (state_q == ST_LOCKED);
    assign SYNC_ERR_CNT = err_q;

endmodule

// File: tb/tb_frame_sync_detector.sv
// Self-checking bench for frame_sync_detector: a frame-level reference model compared every
// cycle, plus hand-computed literal expectations at key stream points.
module tb_frame_sync_detector;

    localparam int          PAY      = 30;
    localparam int          FRAME    = PAY + 2;
    localparam int          LOCK_CNT = 3;
    localparam int          LOSS_CNT = 4;
    localparam logic [15:0] SYNC     = 16'hF628;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN  = 1'b0;
    logic [7:0]  DATA_IN = 8'h00;
    logic [7:0]  DATA_OUT;
    logic        VALID_OUT, SOF_OUT, EOF_OUT, LOCKED;
    logic [15:0] SYNC_ERR_CNT;

    frame_sync_detector #(
        .NBITS(8), .SYNC_WORD(SYNC), .PAYLOAD_LEN(PAY), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT), .SOF_OUT(SOF_OUT), .EOF_OUT(EOF_OUT),
        .LOCKED(LOCKED), .SYNC_ERR_CNT(SYNC_ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    // Reference model: alignment flag, run counters and byte offset since the last sync.
    bit         m_aligned = 1'b0;
    int         m_good    = 0;
    int         m_bad     = 0;
    int         m_since   = 0;
    logic [7:0] m_prev    = 8'h00;
    logic [7:0] exp_data  = 8'h00;
    bit         exp_valid = 1'b0;
    bit         exp_sof   = 1'b0;
    bit         exp_eof   = 1'b0;
    bit         exp_lock  = 1'b0;
    int         exp_err   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit en, input logic [7:0] d);
        bit hit;
        bit was_locked;
        exp_valid = 1'b0;
        exp_sof   = 1'b0;
        exp_eof   = 1'b0;
        if (rst) begin
            m_aligned = 1'b0;
            m_good    = 0;
            m_bad     = 0;
            m_since   = 0;
            m_prev    = 8'h00;
            exp_data  = 8'h00;
            exp_err   = 0;
        end else if (en) begin
            hit        = ({m_prev, d} == SYNC);
            was_locked = m_aligned && (m_good >= LOCK_CNT);
            if (!m_aligned) begin
                if (hit) begin
                    m_aligned = 1'b1;
                    m_good    = 1;
                    m_bad     = 0;
                    m_since   = 0;
                end
            end else begin
                if (was_locked && m_since < PAY) begin
                    exp_valid = 1'b1;
                    exp_data  = d;
                    exp_sof   = (m_since == 0);
                    exp_eof   = (m_since == PAY - 1);
                end
                if (m_since == FRAME - 1) begin
                    m_since = 0;
                    if (hit) begin
                        m_good++;
                        m_bad = 0;
                    end else if (!was_locked) begin
                        m_aligned = 1'b0;
                        m_good    = 0;
                    end else begin
                        m_bad++;
                        if (exp_err < 65535) exp_err++;
                        if (m_bad == LOSS_CNT) begin
                            m_aligned = 1'b0;
                            m_good    = 0;
                            m_bad     = 0;
                        end
                    end
                end else begin
                    m_since++;
                end
            end
            m_prev = d;
        end
        exp_lock = m_aligned && (m_good >= LOCK_CNT);
    endtask

    always @(negedge CLK) begin
        if (cmp_on) begin
            check("valid", 32'(VALID_OUT), 32'(exp_valid));
            check("sof", 32'(SOF_OUT), 32'(exp_sof));
            check("eof", 32'(EOF_OUT), 32'(exp_eof));
            check("locked", 32'(LOCKED), 32'(exp_lock));
            check("err_cnt", 32'(SYNC_ERR_CNT), 32'(exp_err));
            if (exp_valid) check("data", 32'(DATA_OUT), 32'(exp_data));
        end
    end

    task automatic drive(input bit rst, input bit en, input logic [7:0] d);
        RST     = rst;
        EN      = en;
        DATA_IN = d;
        @(posedge CLK);
        model_step(rst, en, d);
        #1;
    endtask

    // With gaps, each byte is followed by an idle cycle carrying the sync LSB as bait.
    task automatic put(input logic [7:0] d, input bit gaps);
        drive(1'b0, 1'b1, d);
        if (gaps) drive(1'b0, 1'b0, 8'h28);
    endtask

    task automatic send_sync(input logic [7:0] lo, input bit gaps);
        put(8'hF6, gaps);
        put(lo, gaps);
    endtask

    task automatic send_payload(input logic [7:0] base, input bit gaps);
        for (int i = 0; i < PAY; i++) put(8'(base + i), gaps);
    endtask

    task automatic send_frame(input logic [7:0] lo, input logic [7:0] base, input bit gaps);
        send_sync(lo, gaps);
        send_payload(base, gaps);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, 32'(DATA_OUT), 32'h0);
        check({tag, "_valid"}, 32'(VALID_OUT), 32'h0);
        check({tag, "_sof"}, 32'(SOF_OUT), 32'h0);
        check({tag, "_eof"}, 32'(EOF_OUT), 32'h0);
        check({tag, "_locked"}, 32'(LOCKED), 32'h0);
        check({tag, "_err"}, 32'(SYNC_ERR_CNT), 32'h0);
    endtask

    initial begin
        // Reset state
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        cmp_on = 1'b1;
        check_idle_outputs("reset");

        // Clean lock: third sync declares lock, next byte is SOF payload 0x00
        send_frame(8'h28, 8'h00, 1'b0);
        send_frame(8'h28, 8'h00, 1'b0);
        put(8'hF6, 1'b0);
        check("lock_before_3rd", 32'(LOCKED), 32'h0);
        put(8'h28, 1'b0);
        check("lock_after_3rd", 32'(LOCKED), 32'h1);
        check("no_valid_on_sync", 32'(VALID_OUT), 32'h0);
        put(8'h00, 1'b0);
        check("first_valid", 32'(VALID_OUT), 32'h1);
        check("first_sof", 32'(SOF_OUT), 32'h1);
        check("first_data", 32'(DATA_OUT), 32'h00);
        for (int i = 1; i < PAY; i++) put(8'(i), 1'b0);
        check("last_eof", 32'(EOF_OUT), 32'h1);
        check("last_data", 32'(DATA_OUT), 32'h1D);
        send_frame(8'h28, 8'h00, 1'b0);
        send_frame(8'h28, 8'h00, 1'b0);
        check("clean_err", 32'(SYNC_ERR_CNT), 32'h0);

        // Single sync error while locked
        send_sync(8'h29, 1'b0);
        check("single_err_cnt", 32'(SYNC_ERR_CNT), 32'h1);
        check("single_err_lock", 32'(LOCKED), 32'h1);
        send_payload(8'h80, 1'b0);
        send_frame(8'h28, 8'h00, 1'b0);

        // Loss of lock after four consecutive bad syncs
        for (int k = 0; k < LOSS_CNT; k++) begin
            send_sync(8'h29, 1'b0);
            check("loss_lock", 32'(LOCKED), (k < LOSS_CNT - 1) ? 32'h1 : 32'h0);
            send_payload(8'h20, 1'b0);
        end
        check("loss_err_cnt", 32'(SYNC_ERR_CNT), 32'h5);
        send_frame(8'h28, 8'h00, 1'b0);
        send_frame(8'h28, 8'h00, 1'b0);
        put(8'hF6, 1'b0);
        check("relock_before", 32'(LOCKED), 32'h0);
        put(8'h28, 1'b0);
        check("relock_after", 32'(LOCKED), 32'h1);
        send_payload(8'h00, 1'b0);

        // EN gaps while locked
        send_frame(8'h28, 8'h40, 1'b1);
        send_frame(8'h28, 8'h40, 1'b1);
        send_sync(8'h28, 1'b1);
        check("gap_err_cnt", 32'(SYNC_ERR_CNT), 32'h5);
        check("gap_lock", 32'(LOCKED), 32'h1);

        // Reset mid-frame at payload index 10
        for (int i = 0; i < 10; i++) put(8'(i), 1'b0);
        drive(1'b1, 1'b1, 8'h0A);
        check_idle_outputs("midrst");
        send_frame(8'h28, 8'h00, 1'b0);
        send_frame(8'h28, 8'h00, 1'b0);
        put(8'hF6, 1'b0);
        check("rst_relock_before", 32'(LOCKED), 32'h0);
        put(8'h28, 1'b0);
        check("rst_relock_after", 32'(LOCKED), 32'h1);
        send_payload(8'h00, 1'b0);

        // False sync at payload index 5..6 while hunting
        drive(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < PAY; i++) begin
            put((i == 5) ? 8'hF6 : (i == 6) ? 8'h28 : 8'(8'h60 + i), 1'b0);
        end
        send_sync(8'h28, 1'b0);
        send_payload(8'h60, 1'b0);
        send_sync(8'h28, 1'b0);
        send_payload(8'h60, 1'b0);
        send_sync(8'h28, 1'b0);
        send_payload(8'h60, 1'b0);
        put(8'hF6, 1'b0);
        check("false_lock_before", 32'(LOCKED), 32'h0);
        put(8'h28, 1'b0);
        check("false_lock_after", 32'(LOCKED), 32'h1);
        send_payload(8'h60, 1'b0);

        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
